// File: rtl/bloque_cargador.sv
// Byte-stream loader and job sequencer for the proof-of-work search core.
// Define HASH_TIMEOUT_EN to end a job after TIMEOUT_CYCLES RUN cycles without a hit.
module bloque_cargador #(
    parameter int unsigned BLOCK_BYTES    = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    output logic [8*BLOCK_BYTES-1:0] bloque_bytes,
    output logic [7:0]               target,
    output logic                     core_reset,
    output logic                     inicio,
    input  logic                     terminado,
    input  logic [23:0]              hash,
    output logic                     busy,
    output logic                     done,
    output logic [23:0]              result_hash,
    output logic [31:0]              run_cycles,
    output logic                     timeout
);

    localparam int unsigned IdxW = $clog2(BLOCK_BYTES + 1);

`ifdef HASH_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef enum logic [1:0] {StLoad, StClear, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [8*BLOCK_BYTES-1:0] bloque_q, bloque_d;
    logic [7:0]               target_q, target_d;
    logic [23:0]              result_q, result_d;
    logic [31:0]              cycles_q, cycles_d;
    logic                     timeout_q, timeout_d;
    logic                     timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StLoad;
            idx_q     <= '0;
            bloque_q  <= '0;
            target_q  <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bloque_q  <= bloque_d;
            target_q  <= target_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bloque_d    = bloque_q;
        target_d    = target_q;
        result_d    = result_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    if (idx_q == IdxW'(BLOCK_BYTES)) begin
                        target_d = in_byte;
                        idx_d    = '0;
                        state_d  = StClear;
                    end else begin
                        // First byte of the stream lands in the most significant lane.
                        for (int k = 0; k < BLOCK_BYTES; k++) begin
                            if (idx_q == IdxW'(k)) begin
                                bloque_d[8*(BLOCK_BYTES-k)-1 -: 8] = in_byte;
                            end
                        end
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StClear: begin
                cycles_d  = '0;
                timeout_d = 1'b0;
                state_d   = StRun;
            end
            StRun: begin
                cycles_d    = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
                timeout_hit = TimeoutEn && (cycles_d >= TIMEOUT_CYCLES);
                // A hit on the same cycle as the limit counts as success.
                if (terminado) begin
                    result_d = hash;
                    state_d  = StDone;
                end else if (timeout_hit) begin
                    result_d  = hash;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StLoad;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    assign in_ready     = (state_q == StLoad);
    assign busy         = (state_q == StClear) || (state_q == StRun);
    assign inicio       = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign core_reset   = reset && (state_q != StClear);
    assign bloque_bytes = bloque_q;
    assign target       = target_q;
    assign result_hash  = result_q;
    assign run_cycles   = cycles_q;
    assign timeout      = TimeoutEn ? timeout_q : 1'b0;

endmodule

// File: tb/tb_bloque_cargador.sv
// Directed bench for bloque_cargador: a job-level reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_bloque_cargador;

    localparam int unsigned BB = 12;
    localparam int unsigned TO = 8;

`ifdef HASH_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          terminado = 1'b0;
    logic [23:0]   hash = 24'h0;
    logic          in_ready, core_reset, inicio, busy, done, timeout;
    logic [8*BB-1:0] bloque_bytes;
    logic [7:0]    target;
    logic [23:0]   result_hash;
    logic [31:0]   run_cycles;

    bloque_cargador #(
        .BLOCK_BYTES   (BB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .bloque_bytes(bloque_bytes),
        .target      (target),
        .core_reset  (core_reset),
        .inicio      (inicio),
        .terminado   (terminado),
        .hash        (hash),
        .busy        (busy),
        .done        (done),
        .result_hash (result_hash),
        .run_cycles  (run_cycles),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;
    int done_seen = 0;
    logic [31:0] done_cycles = '0;
    logic        done_timeout = 1'b0;
    logic [23:0] done_hash = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level reference: 0 loading, 1 clearing core, 2 searching, 3 reporting.
    int          m_mode = 0;
    int          m_idx = 0;
    logic [7:0]  m_hdr [BB];
    logic [7:0]  m_tgt;
    logic [23:0] m_res;
    logic [31:0] m_cyc;
    bit          m_to;

    function automatic logic [8*BB-1:0] hdr_packed();
        logic [8*BB-1:0] v = '0;
        for (int k = 0; k < BB; k++) v = (v << 8) | {{(8*BB-8){1'b0}}, m_hdr[k]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_mode <= 0;
            m_idx  <= 0;
            m_tgt  <= '0;
            m_res  <= '0;
            m_cyc  <= '0;
            m_to   <= 1'b0;
            for (int k = 0; k < BB; k++) m_hdr[k] <= '0;
        end else begin
            case (m_mode)
                0: if (in_valid) begin
                    if (m_idx == BB) begin
                        m_tgt  <= in_byte;
                        m_idx  <= 0;
                        m_mode <= 1;
                    end else begin
                        m_hdr[m_idx] <= in_byte;
                        m_idx        <= m_idx + 1;
                    end
                end
                1: begin
                    m_cyc  <= '0;
                    m_to   <= 1'b0;
                    m_mode <= 2;
                end
                2: begin
                    m_cyc <= (m_cyc == 32'hFFFF_FFFF) ? m_cyc : m_cyc + 32'd1;
                    if (terminado) begin
                        m_res  <= hash;
                        m_mode <= 3;
                    end else if (TimeoutEn && (64'(m_cyc) + 64'd1 >= 64'(TO))) begin
                        m_res  <= hash;
                        m_to   <= 1'b1;
                        m_mode <= 3;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("in_ready", in_ready, m_mode == 0);
            check("busy", busy, (m_mode == 1) || (m_mode == 2));
            check("inicio", inicio, m_mode == 2);
            check("done", done, m_mode == 3);
            check("core_reset", core_reset, reset && (m_mode != 1));
            check("bloque_bytes", bloque_bytes, hdr_packed());
            check("target", target, m_tgt);
            check("result_hash", result_hash, m_res);
            check("run_cycles", run_cycles, m_cyc);
            check("timeout", timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [7:0] base, input int gap_after, input int gap_len,
                            input logic [7:0] tgt);
        for (int k = 0; k <= BB; k++) begin
            in_valid = 1'b1;
            in_byte  = (k == BB) ? tgt : base + 8'(k);
            tick();
            if (k + 1 == gap_after) begin
                in_valid = 1'b0;
                repeat (gap_len) tick();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) tick();
        checking = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;

        // Gap-free load, stub core hits on the 5th RUN cycle.
        load_job(8'h01, 0, 0, 8'h80);
        check("a_hdr", bloque_bytes, 96'h0102030405060708090A0B0C);
        check("a_target", target, 8'h80);
        check("a_clear_core_reset", core_reset, 1'b0);
        check("a_clear_busy", busy, 1'b1);
        tick();
        check("a_run_core_reset", core_reset, 1'b1);
        check("a_run_inicio", inicio, 1'b1);
        repeat (4) tick();
        terminado = 1'b1;
        hash      = 24'h1234AB;
        tick();
        check("a_done", done, 1'b1);
        check("a_result_hash", result_hash, 24'h1234AB);
        check("a_run_cycles", run_cycles, 32'd5);
        tick();
        check("a_in_ready", in_ready, 1'b1);
        check("a_done_low", done, 1'b0);

        // Stuck terminado and a 3-cycle gap after byte 4.
        hash = 24'h777777;
        load_job(8'h01, 4, 3, 8'h80);
        check("b_hdr", bloque_bytes, 96'h0102030405060708090A0B0C);
        check("b_clear_done", done, 1'b0);
        check("b_clear_core_reset", core_reset, 1'b0);
        tick();
        check("b_run_done", done, 1'b0);
        tick();
        check("b_done", done, 1'b1);
        check("b_result_hash", result_hash, 24'h777777);
        check("b_run_cycles", run_cycles, 32'd1);
        terminado = 1'b0;
        tick();

        // Reset mid-RUN at run_cycles = 3.
        load_job(8'hF0, 0, 0, 8'h11);
        check("c_hdr", bloque_bytes, 96'hF0F1F2F3F4F5F6F7F8F9FAFB);
        repeat (4) tick();
        check("c_run_cycles", run_cycles, 32'd3);
        reset = 1'b0;
        tick();
        check("c_in_ready", in_ready, 1'b1);
        check("c_hdr_cleared", bloque_bytes, 96'h0);
        check("c_target", target, 8'h00);
        check("c_run_cycles_cleared", run_cycles, 32'd0);
        check("c_busy", busy, 1'b0);
        check("c_done", done, 1'b0);
        reset = 1'b1;
        tick();

        // No hit: timeout when built in, otherwise waits indefinitely.
        hash = 24'h00C0DE;
        load_job(8'h20, 0, 0, 8'h05);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) begin
                done_seen++;
                done_cycles  = run_cycles;
                done_timeout = timeout;
                done_hash    = result_hash;
            end
        end
        if (TimeoutEn) begin
            check("d_done_count", done_seen, 1);
            check("d_timeout", done_timeout, 1'b1);
            check("d_run_cycles", done_cycles, 32'd8);
            check("d_result_hash", done_hash, 24'h00C0DE);
        end else begin
            check("d_done_count", done_seen, 0);
            check("d_inicio", inicio, 1'b1);
            check("d_run_cycles", run_cycles, 32'd99);
            check("d_timeout", timeout, 1'b0);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bloque_cargador.md
Name: bloque_cargador

Overview:
- Upstream feeder for the proof-of-work search block (nonce generator + micro_ucr hash + target compare).
- Accepts the 12-byte block header plus a 1-byte target as a byte stream with a valid/ready handshake, and presents them as parallel `bloque_bytes`/`target`.
- Clears the sticky search core, asserts `inicio` until the core reports `terminado`, then captures the winning hash and cycle count and signals completion.

Parameters:
- BLOCK_BYTES, 12, header bytes per job; `bloque_bytes` width = 8*BLOCK_BYTES.
- TIMEOUT_CYCLES, 1048576, RUN-state cycle limit; used only with HASH_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- in_valid  input  1  `in_byte` valid.
- in_byte  input  8  header/target byte.
- in_ready  output  1  block accepts a byte this cycle.
- bloque_bytes  output  8*BLOCK_BYTES  assembled header to search core.
- target  output  8  threshold to search core.
- core_reset  output  1  active-low reset to search core.
- inicio  output  1  search enable to core.
- terminado  input  1  sticky found flag from core.
- hash  input  24  core hash output.
- busy  output  1  job in progress (CLEAR or RUN).
- done  output  1  one-cycle completion pulse.
- result_hash  output  24  hash captured at completion.
- run_cycles  output  32  RUN cycles of last job.
- timeout  output  1  last job ended by timeout.

Behaviour:
- Clock/reset: all registers update on posedge clk. `reset`=0 is synchronous and active-low.
- Reset values:
  - state=LOAD, byte index=0.
  - `bloque_bytes`=0, `target`=0, `inicio`=0, `done`=0, `busy`=0.
  - `result_hash`=0, `run_cycles`=0, `timeout`=0.
- `core_reset` = `reset` AND NOT clear_pulse, so the core is held in reset whenever `reset`=0.
- Byte acceptance: a byte is accepted on a cycle with `in_valid`=1 and `in_ready`=1.
- LOAD:
  - `in_ready`=1.
  - Accepted byte k (k=0..BLOCK_BYTES-1) is written to `bloque_bytes[8*(BLOCK_BYTES-k)-1 -: 8]`, i.e. the first byte lands in the MSB.
  - Byte BLOCK_BYTES is written to `target`; the block then goes to CLEAR next cycle and the index returns to 0.
  - `in_valid`=0 stalls the index; there is no timeout in LOAD.
- CLEAR:
  - Exactly 1 cycle; `in_ready`=0, `busy`=1, clear_pulse=1 (`core_reset`=0), `inicio`=0.
  - `run_cycles` cleared to 0, `timeout` cleared to 0.
  - Next state: RUN.
- RUN:
  - `in_ready`=0, `busy`=1, `inicio`=1, `run_cycles` increments by 1 per cycle, saturating at 0xFFFFFFFF.
  - On a cycle where `terminado`=1: latch `hash` into `result_hash`; next state DONE.
- DONE:
  - 1 cycle; `done`=1, `inicio`=0, `busy`=0, `in_ready`=0.
  - Next state: LOAD.
  - `bloque_bytes`, `target`, `result_hash`, `run_cycles` and `timeout` hold until the next CLEAR/LOAD overwrites them.
- Latency:
  - Last byte accepted at cycle N → `core_reset` low at N+1 → `inicio` high from N+2.
  - `terminado` sampled high at cycle M → `done` high at M+1.
- `terminado` is ignored outside RUN. A `terminado` held high from a previous job cannot finish the new job, because CLEAR resets the core first.
- `bloque_bytes` changes only during LOAD, so the core never sees a changing header while `inicio`=1.
- `reset`=0 mid-job (any state): immediate return to reset values; any partial load is discarded.
- Outputs `inicio`, `done`, `busy` and `in_ready` are registered or decoded from the state register only, with no combinational path from `in_valid`.

Optional Feature:
- Macro: HASH_TIMEOUT_EN.
- Defined: in RUN, if `run_cycles` reaches TIMEOUT_CYCLES with `terminado`=0, the block moves to DONE, sets `timeout`=1 and latches the current `hash` into `result_hash`. If `terminado`=1 on that same cycle, success wins and `timeout` stays 0.
- Undefined: no timeout logic is built, `timeout` is tied to 0, and RUN waits for `terminado` indefinitely.

Test Plan:
- Reset, then stream bytes 0x01..0x0C followed by 0x80 with `in_valid` held 1 → after 13 cycles `bloque_bytes`=0x0102030405060708090A0B0C, `target`=0x80; `core_reset`=0 for exactly 1 cycle; `inicio`=1 from the following cycle.
- Stub core raises `terminado` with `hash`=0x1234AB after 5 RUN cycles → `done` pulses 1 cycle one cycle later, `result_hash`=0x1234AB, `run_cycles`=5 on the cycle `done`=1, then `in_ready`=1.
- Drop `in_valid` to 0 for 3 cycles after byte 4 → index holds, final `bloque_bytes` is identical to the gap-free case.
- Hold `terminado`=1 stuck from the prior job, then load a new job → no `done` during CLEAR, `core_reset` pulse seen, `done` only after `terminado` is sampled in RUN.
- Assert `reset`=0 for 1 cycle in RUN at `run_cycles`=3 → all outputs return to reset values the next cycle, `in_ready`=1, no `done` pulse.
- With HASH_TIMEOUT_EN and TIMEOUT_CYCLES=8, `terminado` held 0 → `done`=1 with `timeout`=1, `run_cycles`=8. Without the macro, no `done` pulse after 100 cycles.
